// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Round-robin arbiter sharing one Wishbone-style I/O bridge slave port among
//   NREQ masters. All master-side outputs are registered. A requester that
//   keeps cyc high after its ack (read-modify-write) keeps the grant until it
//   drops cyc.
//
//   Optional build macro IO_ARB_TIMEOUT_EN: adds a WAIT_ACK watchdog that
//   answers with r_err_o and all-ones data after TMO clocks without an ack.
//   Without it r_err_o is tied low and WAIT_ACK waits indefinitely.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   r_cyc_i/r_stb_i/r_we_i        per-requester cycle, strobe, write enable
//   r_sel_i/r_adr_i/r_dat_i       per-requester selects/address/write data (slice k)
//   r_ack_o/r_err_o               one-hot ack / error to the owner
//   r_dat_o                       read data, shared by all requesters
//   m_cyc_o..m_dat_o              bridge request side
//   m_ack_i/m_stall_i/m_dat_i     bridge response side
//   grant_o                       one-hot current owner, 0 when idle
//   busy_o                        arbiter owns the bridge
//
// state     | meaning
// IDLE      | no owner; pick next valid requester round-robin
// WAIT_ACK  | strobe issued to bridge, waiting for ack
// WAIT_NACK | ack/err presented, waiting for owner to drop stb
// HOLD      | owner keeps cyc high between cycles; bus locked to it
module io_bus_arbiter #(
    parameter int NREQ = 4,
    parameter int WID  = 32,
    parameter int TMO  = 1023
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NREQ-1:0]        r_cyc_i,
    input  logic [NREQ-1:0]        r_stb_i,
    input  logic [NREQ-1:0]        r_we_i,
    input  logic [NREQ*WID/8-1:0]  r_sel_i,
    input  logic [NREQ*32-1:0]     r_adr_i,
    input  logic [NREQ*WID-1:0]    r_dat_i,
    output logic [NREQ-1:0]        r_ack_o,
    output logic [NREQ-1:0]        r_err_o,
    output logic [WID-1:0]         r_dat_o,
    output logic                   m_cyc_o,
    output logic                   m_stb_o,
    output logic                   m_we_o,
    output logic [WID/8-1:0]       m_sel_o,
    output logic [31:0]            m_adr_o,
    output logic [WID-1:0]         m_dat_o,
    input  logic                   m_ack_i,
    input  logic                   m_stall_i,
    input  logic [WID-1:0]         m_dat_i,
    output logic [NREQ-1:0]        grant_o,
    output logic                   busy_o
);
    localparam int SW = WID / 8;
    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TMO < 1) begin : g_bad_param
        $error("io_bus_arbiter: NREQ must be 2..8 and TMO >= 1");
    end

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_NACK, HOLD} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     g_idx_q, g_idx_d;
    logic [NREQ-1:0]   grant_d, r_ack_d;
    logic              busy_d, m_cyc_d, m_stb_d, m_we_d;
    logic [WID-1:0]    r_dat_d, m_dat_d;
    logic [SW-1:0]     m_sel_d;
    logic [31:0]       m_adr_d;

    logic [NREQ-1:0]   req_vld;
    logic              win_vld;
    logic [PW-1:0]     win_idx, nxt_ptr, ld_idx;
    logic              ld, clr_bus, rel;

`ifdef IO_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TMO + 1) > 10) ? $clog2(TMO + 1) : 10;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   err_q, err_d;
    assign r_err_o = err_q;
`else
    assign r_err_o = '0;
`endif

    assign req_vld = r_cyc_i & r_stb_i;
    assign nxt_ptr = (g_idx_q == PW'(NREQ - 1)) ? '0 : g_idx_q + 1'b1;

    // Walk downward so the last hit is the closest one at/after rr_ptr.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_vld[idx]) begin
                win_vld = 1'b1;
                win_idx = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        g_idx_d  = g_idx_q;
        grant_d  = grant_o;
        busy_d   = busy_o;
        r_ack_d  = r_ack_o;
        r_dat_d  = r_dat_o;
        m_cyc_d  = m_cyc_o;
        m_stb_d  = m_stb_o;
        m_we_d   = m_we_o;
        m_sel_d  = m_sel_o;
        m_adr_d  = m_adr_o;
        m_dat_d  = m_dat_o;
        ld       = 1'b0;
        ld_idx   = g_idx_q;
        clr_bus  = 1'b0;
        rel      = 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
        err_d    = err_q;
        cnt_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld && !m_ack_i && !m_stall_i) begin
                    g_idx_d = win_idx;
                    grant_d = NREQ'(1) << win_idx;
                    busy_d  = 1'b1;
                    m_cyc_d = 1'b1;
                    m_stb_d = 1'b1;
                    ld      = 1'b1;
                    ld_idx  = win_idx;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // Abort outranks a same-cycle ack.
                if (!r_cyc_i[g_idx_q]) begin
                    rel = 1'b1;
                end else if (m_ack_i) begin
                    r_dat_d = m_dat_i;
                    r_ack_d = grant_o;
                    m_stb_d = 1'b0;
                    state_d = WAIT_NACK;
                end
`ifdef IO_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TMO)) begin
                    err_d   = grant_o;
                    r_dat_d = '1;
                    clr_bus = 1'b1;
                    state_d = WAIT_NACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            WAIT_NACK: begin
                if (!r_stb_i[g_idx_q]) begin
                    r_ack_d = '0;
                    r_dat_d = '0;
`ifdef IO_ARB_TIMEOUT_EN
                    err_d   = '0;
`endif
                    if (r_cyc_i[g_idx_q]) state_d = HOLD;
                    else                  rel     = 1'b1;
                end
            end
            HOLD: begin
                if (!r_cyc_i[g_idx_q]) begin
                    rel = 1'b1;
                end else if (r_stb_i[g_idx_q]) begin
                    m_cyc_d = 1'b1;
                    m_stb_d = 1'b1;
                    ld      = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ld) begin
            m_we_d  = r_we_i[ld_idx];
            m_sel_d = r_sel_i[ld_idx*SW +: SW];
            m_adr_d = r_adr_i[ld_idx*32 +: 32];
            m_dat_d = r_dat_i[ld_idx*WID +: WID];
        end
        if (clr_bus || rel) begin
            m_cyc_d = 1'b0;
            m_stb_d = 1'b0;
            m_we_d  = 1'b0;
            m_sel_d = '0;
            m_adr_d = '0;
            m_dat_d = '0;
        end
        if (rel) begin
            grant_d  = '0;
            busy_d   = 1'b0;
            rr_ptr_d = nxt_ptr;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            g_idx_q  <= '0;
            grant_o  <= '0;
            busy_o   <= 1'b0;
            r_ack_o  <= '0;
            r_dat_o  <= '0;
            m_cyc_o  <= 1'b0;
            m_stb_o  <= 1'b0;
            m_we_o   <= 1'b0;
            m_sel_o  <= '0;
            m_adr_o  <= '0;
            m_dat_o  <= '0;
`ifdef IO_ARB_TIMEOUT_EN
            err_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            g_idx_q  <= g_idx_d;
            grant_o  <= grant_d;
            busy_o   <= busy_d;
            r_ack_o  <= r_ack_d;
            r_dat_o  <= r_dat_d;
            m_cyc_o  <= m_cyc_d;
            m_stb_o  <= m_stb_d;
            m_we_o   <= m_we_d;
            m_sel_o  <= m_sel_d;
            m_adr_o  <= m_adr_d;
            m_dat_o  <= m_dat_d;
`ifdef IO_ARB_TIMEOUT_EN
            err_q    <= err_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter (NREQ=4, WID=32, TMO=15).
module tb_io_bus_arbiter;
    localparam int NREQ = 4;
    localparam int WID  = 32;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [NREQ-1:0]       r_cyc_i = '0, r_stb_i = '0, r_we_i = '0;
    logic [NREQ*4-1:0]     r_sel_i = '0;
    logic [NREQ*32-1:0]    r_adr_i = '0;
    logic [NREQ*WID-1:0]   r_dat_i = '0;
    logic [NREQ-1:0]       r_ack_o, r_err_o, grant_o;
    logic [WID-1:0]        r_dat_o, m_dat_o;
    logic                  m_cyc_o, m_stb_o, m_we_o, busy_o;
    logic [3:0]            m_sel_o;
    logic [31:0]           m_adr_o;
    logic                  m_ack_i = 1'b0, m_stall_i = 1'b0;
    logic [WID-1:0]        m_dat_i = '0;

    int n_chk = 0;
    int n_pass = 0;

    io_bus_arbiter #(.NREQ(NREQ), .WID(WID), .TMO(15)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .r_cyc_i(r_cyc_i), .r_stb_i(r_stb_i), .r_we_i(r_we_i),
        .r_sel_i(r_sel_i), .r_adr_i(r_adr_i), .r_dat_i(r_dat_i),
        .r_ack_o(r_ack_o), .r_err_o(r_err_o), .r_dat_o(r_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
        .m_ack_i(m_ack_i), .m_stall_i(m_stall_i), .m_dat_i(m_dat_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int k, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat);
        r_cyc_i[k] = cyc;
        r_stb_i[k] = stb;
        r_we_i[k]  = we;
        r_sel_i[k*4 +: 4]    = 4'hF;
        r_adr_i[k*32 +: 32]  = adr;
        r_dat_i[k*WID +: WID] = dat;
    endtask

    task automatic wait_issue(input string tag);
        int n;
        n = 0;
        while (!m_stb_o && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_issue"}, m_stb_o, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, {m_cyc_o, m_stb_o, m_we_o, busy_o, grant_o, r_ack_o, r_err_o}, 0);
        chk({tag, "_data"}, {m_adr_o, r_dat_o}, 0);
    endtask

    task automatic do_reset;
        r_cyc_i = '0;
        r_stb_i = '0;
        m_ack_i = 1'b0;
        m_stall_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk_idle("reset");
        tick;
        rst_ni = 1'b1;
    endtask

    initial begin : main
        int ord[8];
        int rem[4];
        int k;
        logic leak;
        ord = '{0, 1, 2, 3, 0, 1, 2, 3};

        #12;
        chk_idle("por");
        rst_ni = 1'b1;
        tick;

        // Single read by requester 0
        set_req(0, 1, 1, 0, 32'hFD0A_0000, 32'h0);
        tick;
        chk("rd_stb_lat", {m_cyc_o, m_stb_o, m_we_o, busy_o, grant_o}, 8'b1101_0001);
        chk("rd_adr", m_adr_o, 32'hFD0A_0000);
        tick;
        tick;
        chk("rd_noack_yet", r_ack_o, 0);
        m_ack_i = 1'b1;
        m_dat_i = 32'h1234_5678;
        tick;
        m_ack_i = 1'b0;
        chk("rd_ack", {r_ack_o, m_stb_o}, 5'b0001_0);
        chk("rd_dat", r_dat_o, 32'h1234_5678);
        tick;
        chk("rd_ack_held", r_ack_o, 4'b0001);
        set_req(0, 0, 0, 0, 32'h0, 32'h0);
        tick;
        chk_idle("rd_release");

        // Round-robin contention, two cycles per requester
        do_reset;
        for (int j = 0; j < 4; j++) begin
            rem[j] = 2;
            set_req(j, 1, 1, 0, 32'hFD00_0000 + 32'(j * 16), 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            k = ord[i];
            wait_issue($sformatf("rr%0d", i));
            chk($sformatf("rr%0d_grant", i), grant_o, 64'(1) << k);
            chk($sformatf("rr%0d_adr", i), m_adr_o, 32'hFD00_0000 + 32'(k * 16));
            m_ack_i = 1'b1;
            m_dat_i = 32'hA000_0000 + 32'(i);
            tick;
            m_ack_i = 1'b0;
            chk($sformatf("rr%0d_ack", i), {r_ack_o, r_dat_o}, {4'(1 << k), 32'hA000_0000 + 32'(i)});
            set_req(k, 0, 0, 0, 32'hFD00_0000 + 32'(k * 16), 32'h0);
            rem[k]--;
            tick;
            chk($sformatf("rr%0d_rel", i), {grant_o, r_ack_o}, 0);
            if (rem[k] > 0) set_req(k, 1, 1, 0, 32'hFD00_0000 + 32'(k * 16), 32'h0);
        end

        // RMW lock: requester 1 holds cyc, requester 2 must wait
        set_req(1, 1, 1, 0, 32'hFD0B_0004, 32'h0);
        set_req(2, 1, 1, 0, 32'hFD0C_0000, 32'h0);
        tick;
        chk("rmw_rd_grant", {grant_o, m_stb_o, m_we_o}, 6'b0010_10);
        m_ack_i = 1'b1;
        m_dat_i = 32'hCAFE_0001;
        tick;
        m_ack_i = 1'b0;
        chk("rmw_rd_ack", {r_ack_o, r_dat_o}, {4'b0010, 32'hCAFE_0001});
        r_stb_i[1] = 1'b0;
        tick;
        tick;
        tick;
        chk("rmw_hold", {grant_o, r_ack_o, m_cyc_o, m_stb_o}, 10'b0010_0000_10);
        set_req(1, 1, 1, 1, 32'hFD0B_0004, 32'hDEAD_BEEF);
        tick;
        chk("rmw_wr_issue", {grant_o, m_cyc_o, m_stb_o, m_we_o}, 7'b0010_111);
        chk("rmw_wr_dat", {m_adr_o, m_dat_o}, {32'hFD0B_0004, 32'hDEAD_BEEF});
        m_ack_i = 1'b1;
        tick;
        m_ack_i = 1'b0;
        chk("rmw_wr_ack", {r_ack_o, m_cyc_o}, 5'b0010_1);
        set_req(1, 0, 0, 0, 32'h0, 32'h0);
        tick;
        chk("rmw_release", {grant_o, m_cyc_o}, 0);
        tick;
        chk("rmw_next_grant", {grant_o, m_stb_o}, 5'b0100_1);

        // Abort by requester 2 before ack, then a late ack
        tick;
        set_req(2, 0, 0, 0, 32'h0, 32'h0);
        tick;
        chk_idle("abort");
        m_ack_i = 1'b1;
        m_dat_i = 32'h5555_AAAA;
        tick;
        m_ack_i = 1'b0;
        chk_idle("late_ack");

        // Stall holds off requester 3, then reset mid WAIT_ACK
        m_stall_i = 1'b1;
        set_req(3, 1, 1, 0, 32'hFD0C_0008, 32'h0);
        leak = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (m_stb_o) leak = 1'b1;
        end
        chk("stall_hold", leak, 0);
        m_stall_i = 1'b0;
        tick;
        chk("stall_issue", {grant_o, m_stb_o}, 5'b1000_1);
        tick;
        #2;
        rst_ni = 1'b0;
        #1;
        chk_idle("async_rst");
        set_req(3, 0, 0, 0, 32'h0, 32'h0);
        tick;
        rst_ni = 1'b1;
        tick;

        // Watchdog (TMO=15 on this instance)
        set_req(0, 1, 1, 0, 32'hFD0D_0000, 32'h0);
        tick;
        chk("tmo_issue", {grant_o, m_stb_o}, 5'b0001_1);
`ifdef IO_ARB_TIMEOUT_EN
        repeat (15) tick;
        chk("tmo_early", r_err_o, 0);
        tick;
        chk("tmo_err", {r_err_o, r_ack_o, m_cyc_o, m_stb_o}, 10'b0001_0000_00);
        chk("tmo_dat", r_dat_o, 32'hFFFF_FFFF);
        set_req(0, 0, 0, 0, 32'h0, 32'h0);
        tick;
        chk_idle("tmo_release");
`else
        repeat (20) tick;
        chk("no_tmo", {r_err_o, m_stb_o, grant_o}, 9'b0000_1_0001);
        set_req(0, 0, 0, 0, 32'h0, 32'h0);
        tick;
        chk_idle("no_tmo_abort");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : guard
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Round-robin arbiter that shares the single I/O bridge slave port (classic Wishbone-style cyc/stb/ack) among NREQ bus masters (CPU cores, DMA, debug).
- Sits between the requesters and the I/O bridge.
- Registers all master-side outputs, holds the grant across read-modify-write cycles (cyc held high) and returns ack/data to the granted requester only.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WID, 32, data width; select width is WID/8.
- TMO, 1023, watchdog limit in clocks (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- r_cyc_i  in  NREQ  per-requester cycle.
- r_stb_i  in  NREQ  per-requester strobe.
- r_we_i  in  NREQ  per-requester write enable.
- r_sel_i  in  NREQ*WID/8  byte selects, requester k at slice k.
- r_adr_i  in  NREQ*32  addresses, requester k at slice k.
- r_dat_i  in  NREQ*WID  write data, requester k at slice k.
- r_ack_o  out  NREQ  ack, one-hot to the granted requester.
- r_err_o  out  NREQ  error, one-hot (optional feature only, else 0).
- r_dat_o  out  WID  read data, shared by all requesters.
- m_cyc_o  out  1  to bridge: cycle.
- m_stb_o  out  1  to bridge: strobe.
- m_we_o  out  1  to bridge: write enable.
- m_sel_o  out  WID/8  to bridge: byte selects.
- m_adr_o  out  32  to bridge: address.
- m_dat_o  out  WID  to bridge: write data.
- m_ack_i  in  1  bridge ack.
- m_stall_i  in  1  bridge stall.
- m_dat_i  in  WID  bridge read data.
- grant_o  out  NREQ  one-hot current owner, 0 when idle.
- busy_o  out  1  arbiter owns the bridge.

Behaviour:
- Reset (rst_ni low, asynchronous) clears all outputs to 0, rr_ptr to 0, state to IDLE. Reset mid-cycle drops m_cyc_o/m_stb_o immediately.
- Request k is valid when r_cyc_i[k] & r_stb_i[k].
- States: IDLE, WAIT_ACK, WAIT_NACK, HOLD.
- IDLE:
  - If a request is valid, m_ack_i=0 and m_stall_i=0, pick the first valid requester searching from rr_ptr upward with wrap.
  - Next edge: grant_o/busy_o set; m_cyc_o=m_stb_o=1; m_we/sel/adr/dat_o latched from the winner's slices; state goes to WAIT_ACK.
  - Request-to-m_stb_o latency is 1 clock.
- WAIT_ACK:
  - On m_ack_i: r_dat_o<=m_dat_i, r_ack_o[g]<=1, m_stb_o<=0, state goes to WAIT_NACK. Ack latency is 1 clock after m_ack_i.
  - If r_cyc_i[g]=0 (abort): clear the whole bus, release the grant, state goes to IDLE. Takes priority if ack and abort arrive in the same cycle.
- WAIT_NACK:
  - r_ack_o[g] stays high until r_stb_i[g]=0, then ack and r_dat_o clear.
  - If r_cyc_i[g] is still 1 (RMW), state goes to HOLD with m_cyc_o kept high; otherwise m_cyc_o=0, grant released, state goes to IDLE.
- HOLD:
  - Owner g keeps the grant; other requesters are ignored.
  - New r_stb_i[g]=1: re-latch controls, m_stb_o=1, state goes to WAIT_ACK.
  - r_cyc_i[g]=0: release, state goes to IDLE.
- rr_ptr <= (g+1) mod NREQ on every release, so a single continuous requester cannot starve the others.
- Never more than one bit set in grant_o or r_ack_o. Ack is never asserted to a non-granted requester.
- m_stall_i is sampled only in IDLE. m_ack_i arriving in IDLE or HOLD is ignored.

Optional Feature:
- Macro: IO_ARB_TIMEOUT_EN.
- Defined:
  - A 10-bit-or-wider counter runs in WAIT_ACK and resets on entry.
  - When it reaches TMO: r_err_o[g]<=1 and r_dat_o<=all-ones; the bus is cleared; state goes to WAIT_NACK, where err behaves like ack (held until stb drops).
- Undefined: no counter; r_err_o tied to 0; WAIT_ACK waits indefinitely.

Test Plan:
- Single read: req0 reads 0xFD0A0000, bridge acks 3 clocks later with 0x12345678 -> m_stb_o 1 clock after request; r_ack_o=0001 and r_dat_o=0x12345678 1 clock after m_ack_i; held until stb drop.
- Contention: req0..3 all request together, each issuing 2 cycles -> grant order 0,1,2,3,0,1,2,3; never two grant bits set.
- RMW lock: req1 holds cyc across read then write to 0xFD0B0004 while req2 requests -> req2 granted only after req1 drops cyc; m_cyc_o high throughout req1's sequence.
- Abort: req2 drops cyc in WAIT_ACK before ack, then a late m_ack_i arrives -> no r_ack_o; bus cleared; state IDLE; late ack ignored.
- Stall plus reset: m_stall_i=1 holds off a request for 5 clocks -> issue occurs 1 clock after stall drops. rst_ni pulsed low mid-WAIT_ACK -> all outputs 0 immediately.
- IO_ARB_TIMEOUT_EN with TMO=15, bridge never acks -> r_err_o[g]=1 and r_dat_o=0xFFFFFFFF exactly 16 clocks after issue; bus cleared.
